// File: rtl/regfile_dump_if.sv
// Signal bundle between regfile_dump, the regfile read port 1 (ra1/rd1) and the dump consumer.
// master = the dump engine, slave = regfile/consumer side.
interface regfile_dump_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          start;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    modport master (
        input  start, rd, out_ready,
        output ra, out_data, out_addr, out_valid, out_last, busy, done
    );

    modport slave (
        output start, rd, out_ready,
        input  ra, out_data, out_addr, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: sweeps registers FIRST_REG..LAST_REG over regfile read port 1 and streams them out.
// Optional macro REGDUMP_CHECKSUM_EN adds a modulo-2**DW running sum of the words accepted in a sweep.
module regfile_dump #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic           clk,
    input  logic           reset,
`ifdef REGDUMP_CHECKSUM_EN
    output logic [DW-1:0]  checksum,
`endif
    regfile_dump_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [AW-1:0] FIRST_A = AW'(FIRST_REG);
    localparam logic [AW-1:0] LAST_A  = AW'(LAST_REG);

    state_t        state, state_nxt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_p1;
    logic [AW-1:0] idx_p1;
    logic          last_p1;
    logic          vld_p1;
    logic          accept;

    assign accept = (state == SEND) && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = READ;
            READ:    state_nxt = SEND;
            SEND:    if (bus.out_ready) state_nxt = last_p1 ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture stage: rd is sampled on the edge leaving READ, so a write landing on that edge is not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr    <= '0;
            data_p1 <= '0;
            idx_p1  <= '0;
            last_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) addr <= FIRST_A;
                READ: begin
                    data_p1 <= bus.rd;
                    idx_p1  <= addr;
                    last_p1 <= (addr == LAST_A);
                    vld_p1  <= 1'b1;
                end
                SEND: if (bus.out_ready) begin
                    vld_p1 <= 1'b0;
                    if (last_p1) last_p1 <= 1'b0;
                    else         addr    <= addr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.ra        = addr;
    assign bus.out_data  = data_p1;
    assign bus.out_addr  = idx_p1;
    assign bus.out_valid = vld_p1;
    assign bus.out_last  = last_p1;
    assign bus.busy      = (state == READ) || (state == SEND);
    assign bus.done      = (state == DONE);

`ifdef REGDUMP_CHECKSUM_EN
    logic [DW-1:0] sum_q;

    function automatic logic [DW-1:0] sum_wrap(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a + b;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          sum_q <= '0;
        else if (state == IDLE && bus.start) sum_q <= '0;
        else if (accept)                    sum_q <= sum_wrap(sum_q, data_p1);
    end

    assign checksum = sum_q;
`endif
endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a full-range instance (0..31) and a single-register instance (5..5)
// checked every cycle against a transaction-level model of the dump stream.
module tb_regfile_dump;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    start, ready;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rf [32];
    int            vectors = 0;
    int            miscompares = 0;

    logic [1:0]    done_v, valid_v, busy_v, last_v;
    logic [AW-1:0] ra_v [2];
    logic [AW-1:0] oaddr_v [2];
    logic [DW-1:0] odata_v [2];
`ifdef REGDUMP_CHECKSUM_EN
    logic [DW-1:0] csum_v [2];
`endif

    always #5 clk = ~clk;

    // Regfile write port; x0 is hardwired to zero on the read side.
    always_ff @(posedge clk) if (we && wa != '0) rf[wa] <= wd;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int F = (g == 0) ? 0 : 5;
        localparam int L = (g == 0) ? 31 : 5;

        regfile_dump_if #(.DW(DW), .AW(AW)) bus ();

        assign bus.start     = start[g];
        assign bus.out_ready = ready[g];
        assign bus.rd        = (bus.ra == '0) ? '0 : rf[bus.ra];
        assign done_v[g]     = bus.done;
        assign valid_v[g]    = bus.out_valid;
        assign busy_v[g]     = bus.busy;
        assign last_v[g]     = bus.out_last;
        assign ra_v[g]       = bus.ra;
        assign oaddr_v[g]    = bus.out_addr;
        assign odata_v[g]    = bus.out_data;

`ifdef REGDUMP_CHECKSUM_EN
        regfile_dump #(.DW(DW), .AW(AW), .FIRST_REG(F), .LAST_REG(L)) dut (
            .clk(clk), .reset(reset), .checksum(csum_v[g]), .bus(bus));
`else
        regfile_dump #(.DW(DW), .AW(AW), .FIRST_REG(F), .LAST_REG(L)) dut (
            .clk(clk), .reset(reset), .bus(bus));
`endif

        int            cyc = 0, rise_at = -1, done_at = -1, nxt = 0;
        int            acc_cyc = 0, fin_cyc = 0, n_words = 0, n_sweeps = 0;
        bit            in_sweep = 1'b0, hold = 1'b0, s_start = 1'b0, s_ready = 1'b0;
        logic          p_valid = 1'b0, p_last = 1'b0;
        logic [AW-1:0] p_addr = '0;
        logic [DW-1:0] p_data = '0, m_sum = '0, want;
        logic [DW-1:0] snap [32];
        logic [DW-1:0] dump [32];

        always @(posedge clk) begin
            s_start = start[g];
            s_ready = ready[g];
        end

        always @(negedge clk) begin
            cyc++;
            if (reset) begin
                chk("rst_valid", bus.out_valid, 0);
                chk("rst_data", bus.out_data, 0);
                chk("rst_addr", bus.out_addr, 0);
                chk("rst_last", bus.out_last, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_done", bus.done, 0);
                chk("rst_ra", bus.ra, 0);
`ifdef REGDUMP_CHECKSUM_EN
                chk("rst_csum", csum_v[g], 0);
`endif
                in_sweep = 0; hold = 0; rise_at = -1; done_at = -1;
                m_sum = '0; p_valid = 1'b0;
            end else begin
                // Events of the edge just gone.
                if (done_at == cyc - 1) in_sweep = 0;
                else if (!in_sweep && s_start) begin
                    in_sweep = 1; nxt = F; rise_at = cyc + 1; acc_cyc = cyc - 1; m_sum = '0;
                end
                if (p_valid && s_ready) begin
                    n_words++;
                    dump[p_addr] = p_data;
                    m_sum = m_sum + p_data;
                    if (nxt == L) done_at = cyc;
                    else begin nxt++; rise_at = cyc + 1; end
                end
                hold = p_valid && !s_ready;

                if (rise_at == cyc) begin
                    want = (nxt == 0) ? '0 : snap[nxt];
                    chk("word_valid", bus.out_valid, 1);
                    chk("word_addr", bus.out_addr, nxt);
                    chk("word_data", bus.out_data, want);
                    chk("word_last", bus.out_last, nxt == L);
                end else chk("valid", bus.out_valid, hold);
                if (hold) begin
                    chk("hold_data", bus.out_data, p_data);
                    chk("hold_addr", bus.out_addr, p_addr);
                    chk("hold_last", bus.out_last, p_last);
                end
                if (rise_at == cyc + 1) chk("read_ra", bus.ra, nxt);
                chk("done", bus.done, done_at == cyc);
                chk("busy", bus.busy, in_sweep && done_at != cyc);
                if (done_at == cyc) begin
                    chk("done_ra", bus.ra, L);
                    fin_cyc = cyc;
                    n_sweeps++;
                end
`ifdef REGDUMP_CHECKSUM_EN
                chk("csum", csum_v[g], m_sum);
`endif
                p_valid = bus.out_valid;
                p_data  = bus.out_data;
                p_addr  = bus.out_addr;
                p_last  = bus.out_last;
            end
            for (int i = 0; i < 32; i++) snap[i] = rf[i];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(int a, logic [DW-1:0] d);
        we = 1'b1; wa = AW'(a); wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic clear_rf();
        for (int i = 1; i < 32; i++) wr(i, '0);
    endtask

    task automatic wait_done(int g, int budget);
        int i = 0;
        while (!done_v[g] && i < budget) begin tick(); i++; end
        if (!done_v[g]) begin
            vectors++; miscompares++;
            $display("FAIL wait_done lane%0d: no done within %0d cycles", g, budget);
        end
    endtask

    task automatic wait_word(int g, int a, int budget);
        int i = 0;
        while (!(valid_v[g] && oaddr_v[g] == AW'(a)) && i < budget) begin tick(); i++; end
        if (i >= budget) begin
            vectors++; miscompares++;
            $display("FAIL wait_word lane%0d: addr %0d not offered within %0d cycles", g, a, budget);
        end
    endtask

    task automatic sweep(int g, int budget);
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
        wait_done(g, budget);
        tick();
    endtask

    initial begin
        int n0;
        reset = 1'b1; start = '0; ready = '0; we = 1'b0; wa = '0; wd = '0;
        repeat (3) tick();
        chk("reset_valid", valid_v[0], 0);
        chk("reset_busy", busy_v[0], 0);
        chk("reset_ra", ra_v[0], 0);
        reset = 1'b0;
        tick();

        // Full sweep with ready tied high.
        clear_rf();
        wr(1, 32'h10); wr(2, 32'h15); wr(31, 32'hDEADBEEF);
        ready[0] = 1'b1;
        n0 = lane[0].n_words;
        sweep(0, 200);
        chk("full_words", lane[0].n_words - n0, 32);
        chk("full_x0", lane[0].dump[0], 32'h0);
        chk("full_x1", lane[0].dump[1], 32'h10);
        chk("full_x2", lane[0].dump[2], 32'h15);
        chk("full_x31", lane[0].dump[31], 32'hDEADBEEF);
        chk("latency", lane[0].fin_cyc - lane[0].acc_cyc, 65);

        // Backpressure on addr 2 for 7 cycles.
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        wait_word(0, 2, 50);
        ready[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("bp_valid", valid_v[0], 1);
            chk("bp_data", odata_v[0], 32'h15);
            chk("bp_addr", oaddr_v[0], 2);
        end
        ready[0] = 1'b1;
        wait_done(0, 200);
        tick();

        // Write x3 on the very edge that captures addr 3.
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        begin
            int i = 0;
            while (!(ra_v[0] == AW'(3) && busy_v[0] && !valid_v[0]) && i < 50) begin tick(); i++; end
        end
        wr(3, 32'h14);
        wait_done(0, 200);
        tick();
        chk("wcap_old", lane[0].dump[3], 32'h0);
        sweep(0, 200);
        chk("wcap_new", lane[0].dump[3], 32'h14);

        // Single-register instance; start pulses during SEND are ignored.
        wr(5, 32'hA5A5A5A5);
        n0 = lane[1].n_words;
        ready[1] = 1'b0;
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        wait_word(1, 5, 20);
        chk("single_last", last_v[1], 1);
        start[1] = 1'b1; tick(); tick(); start[1] = 1'b0;
        ready[1] = 1'b1;
        wait_done(1, 20);
        tick();
        ready[1] = 1'b0;
        chk("single_words", lane[1].n_words - n0, 1);
        chk("single_data", lane[1].dump[5], 32'hA5A5A5A5);

        // Reset while SEND at addr 10, then a fresh sweep.
        ready[0] = 1'b1;
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        wait_word(0, 10, 100);
        ready[0] = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_valid", valid_v[0], 0);
        chk("midrst_busy", busy_v[0], 0);
        chk("midrst_ra", ra_v[0], 0);
        chk("midrst_done", done_v[0], 0);
        tick(); tick();
        reset = 1'b0;
        ready[0] = 1'b1;
        n0 = lane[0].n_words;
        sweep(0, 200);
        chk("rerun_words", lane[0].n_words - n0, 32);

`ifdef REGDUMP_CHECKSUM_EN
        clear_rf();
        wr(1, 32'h1); wr(2, 32'h2); wr(3, 32'hFFFFFFFF);
        sweep(0, 200);
        chk("checksum", csum_v[0], 32'h2);
`endif

        // Randomized traffic: register contents, backpressure, start pulses, writes and resets.
        for (int i = 1; i < 32; i++) wr(i, $urandom);
        n0 = lane[0].n_sweeps;
        for (int c = 0; c < 4000; c++) begin
            if (reset) begin
                reset = 1'b0;
                start = '0;
            end else begin
                reset = ($urandom_range(0, 599) == 0);
                start[0] = ($urandom_range(0, 7) == 0);
                start[1] = ($urandom_range(0, 7) == 0);
            end
            ready[0] = ($urandom_range(0, 3) != 0);
            ready[1] = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 3) == 0);
            wa = AW'($urandom);
            wd = $urandom;
            tick();
        end
        reset = 1'b0; start = '0; we = 1'b0;
        chk("rand_progress", lane[0].n_sweeps > n0, 1);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
